// File: rtl/mem_arbiter.sv
// Purpose : round-robin arbiter giving two bus masters shared access to a single-port RAM.
// Latency : writes complete at the end of the grant cycle; read data returns READ_LAT+1 cycles after grant.
// Backpress: a requester holds its request until gnt; no grant is issued while a read is in flight.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req0/1, we0/1              request and write-enable from master 0 (CPU) / master 1 (loader)
//   addr0/1, wdata0/1          request address and write data
//   gnt0/1                     combinational accept strobe (only while idle)
//   rvalid0/1, rdata           one-cycle read-return strobe per master, shared registered data
//   ram_address, ram_data,
//   ram_rden, ram_wren, ram_q  single-port RAM interface
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_t;

  // One master's request bundled so the winner can be selected in one mux.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic [2:0] CNT_LOAD = 3'(READ_LAT - 1);

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              lg, lg_nxt;
  logic              own, own_nxt;
  logic [ADDR_W-1:0] raddr, raddr_nxt;

  req_t req_a, req_b, req_sel;
  logic pick;

  assign req_a   = '{we: we0, addr: addr0, wdata: wdata0};
  assign req_b   = '{we: we1, addr: addr1, wdata: wdata1};
  // On a tie the master that was not granted last wins; a sole requester always wins.
  assign pick    = (req0 && req1) ? !lg : req1;
  assign req_sel = pick ? req_b : req_a;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    lg_nxt      = lg;
    own_nxt     = own;
    raddr_nxt   = raddr;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    ram_rden    = 1'b0;
    ram_wren    = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          gnt0        = !pick;
          gnt1        = pick;
          lg_nxt      = pick;
          ram_address = req_sel.addr;
          if (req_sel.we) begin
            // Write completes at the closing edge; arbiter stays free.
            ram_wren = 1'b1;
            ram_data = req_sel.wdata;
          end else begin
            ram_rden  = 1'b1;
            raddr_nxt = req_sel.addr;
            own_nxt   = pick;
            cnt_nxt   = CNT_LOAD;
            state_nxt = (READ_LAT == 1) ? RD_DONE : RD_WAIT;
          end
        end
      end

      RD_WAIT: begin
        // Keep the address and read enable up for the rest of the RAM latency.
        ram_address = raddr;
        ram_rden    = 1'b1;
        cnt_nxt     = cnt - 3'd1;
        if (cnt == 3'd1) begin
          state_nxt = RD_DONE;
        end
      end

      RD_DONE: begin
        // ram_q is valid this cycle and is captured at the closing edge.
        ram_address = raddr;
        state_nxt   = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      lg      <= 1'b1;
      own     <= 1'b0;
      raddr   <= '0;
      rdata   <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      lg      <= lg_nxt;
      own     <= own_nxt;
      raddr   <= raddr_nxt;
      rvalid0 <= (state == RD_DONE) && !own;
      rvalid1 <= (state == RD_DONE) && own;
      if (state == RD_DONE) begin
        rdata <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : randomized check of two mem_arbiter instances (READ_LAT 2 and 4) against a transaction model.
// Latency : model predicts grants, RAM controls, rvalid and rdata cycle by cycle.
// Backpress: bench masters hold each request until the model predicts its grant.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic        req0    [2];
  logic        req1    [2];
  logic        we0     [2];
  logic        we1     [2];
  logic [15:0] addr0   [2];
  logic [15:0] addr1   [2];
  logic [7:0]  wdata0  [2];
  logic [7:0]  wdata1  [2];
  logic        gnt0    [2];
  logic        gnt1    [2];
  logic        rvalid0 [2];
  logic        rvalid1 [2];
  logic [7:0]  rdata   [2];
  logic [15:0] ram_address [2];
  logic [7:0]  ram_data    [2];
  logic        ram_rden    [2];
  logic        ram_wren    [2];
  logic [7:0]  ram_q       [2];

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .READ_LAT(2)) u_lat2 (
    .clk(clk), .reset(rst[0]),
    .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
    .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .rvalid0(rvalid0[0]), .rvalid1(rvalid1[0]),
    .rdata(rdata[0]), .ram_address(ram_address[0]), .ram_data(ram_data[0]),
    .ram_rden(ram_rden[0]), .ram_wren(ram_wren[0]), .ram_q(ram_q[0])
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .READ_LAT(4)) u_lat4 (
    .clk(clk), .reset(rst[1]),
    .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
    .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .rvalid0(rvalid0[1]), .rvalid1(rvalid1[1]),
    .rdata(rdata[1]), .ram_address(ram_address[1]), .ram_data(ram_data[1]),
    .ram_rden(ram_rden[1]), .ram_wren(ram_wren[1]), .ram_q(ram_q[1])
  );

  function automatic int lat(input int k);
    return (k != 0) ? 4 : 2;
  endfunction

  // Preloaded RAM contents for never-written locations.
  function automatic logic [7:0] init_val(input int k, input logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b01} ^ ((k != 0) ? 8'h3C : 8'hA5);
  endfunction

  // RAM behavioural models: bit 8 marks a written location.
  bit   [8:0] mem  [2][16384];
  logic [7:0] pipe [2][8];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_wren[k]) mem[k][ram_address[k][13:0]] <= {1'b1, ram_data[k]};
      for (int i = 7; i > 0; i--) pipe[k][i] <= pipe[k][i-1];
      if (ram_rden[k])
        pipe[k][0] <= mem[k][ram_address[k][13:0]][8] ? mem[k][ram_address[k][13:0]][7:0]
                                                       : init_val(k, ram_address[k][13:0]);
      else
        pipe[k][0] <= 8'h00;
    end
  end

  assign ram_q[0] = pipe[0][1];
  assign ram_q[1] = pipe[1][3];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bench masters.
  bit         act [2][2];
  bit         dwe [2][2];
  logic [13:0] dadr [2][2];
  logic [7:0]  dwd  [2][2];

  // Reference model (transaction level).
  bit   [8:0] ref_mem [2][16384];
  int         free_at [2];
  bit         lg_m [2];
  bit         rd_on [2];
  int         rd_start [2];
  logic [13:0] rd_addr [2];
  bit         pend_on [2];
  int         pend_due [2];
  bit         pend_own [2];
  logic [7:0] pend_dat [2];
  logic [7:0] exp_rdata [2];
  bit         rst_next [2];
  int         n_rst [2];
  int         force_at [2];

  function automatic logic [7:0] ref_rd(input int k, input logic [13:0] a);
    return ref_mem[k][a][8] ? ref_mem[k][a][7:0] : init_val(k, a);
  endfunction

  task automatic drive(input int k, input int cyc);
    for (int m = 0; m < 2; m++) begin
      if (rst[k]) begin
        act[k][m] = 1'b0;
      end else if (!act[k][m]) begin
        if (cyc == force_at[k] || $urandom_range(0, 99) < ((cyc < 60) ? 100 : 35)) begin
          act[k][m]  = 1'b1;
          dwe[k][m]  = (cyc < 60 || cyc == force_at[k]) ? 1'b0 : 1'($urandom_range(0, 1));
          dadr[k][m] = ($urandom_range(0, 1) != 0) ? 14'($urandom_range(0, 15))
                                                   : 14'($urandom_range(0, 16383));
          dwd[k][m]  = 8'($urandom);
        end
      end
    end
    req0[k]   = act[k][0];
    req1[k]   = act[k][1];
    we0[k]    = act[k][0] ? dwe[k][0] : 1'($urandom);
    we1[k]    = act[k][1] ? dwe[k][1] : 1'($urandom);
    addr0[k]  = act[k][0] ? {2'b00, dadr[k][0]} : 16'($urandom);
    addr1[k]  = act[k][1] ? {2'b00, dadr[k][1]} : 16'($urandom);
    wdata0[k] = act[k][0] ? dwd[k][0] : 8'($urandom);
    wdata1[k] = act[k][1] ? dwd[k][1] : 8'($urandom);
  endtask

  task automatic model_reset(input int k, input int t);
    free_at[k]   = t + 1;
    lg_m[k]      = 1'b1;
    rd_on[k]     = 1'b0;
    pend_on[k]   = 1'b0;
    exp_rdata[k] = 8'h00;
  endtask

  task automatic model_step(input int k, input int t);
    bit r0, r1, g, w, ev0, ev1, e_rden, e_wren, cd;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    int L;
    L  = lat(k);
    r0 = act[k][0];
    r1 = act[k][1];
    g  = (t >= free_at[k]) && (r0 || r1);
    w  = 1'b0;
    if (r0 && r1) w = (lg_m[k] == 1'b0);
    else          w = r1;

    ev0 = 1'b0;
    ev1 = 1'b0;
    if (pend_on[k] && pend_due[k] == t) begin
      if (pend_own[k]) ev1 = 1'b1;
      else             ev0 = 1'b1;
      exp_rdata[k] = pend_dat[k];
      pend_on[k]   = 1'b0;
    end

    cd = 1'b0; e_data = 8'h00; e_addr = 16'h0000; e_rden = 1'b0; e_wren = 1'b0;
    if (rd_on[k] && t > rd_start[k] && t <= rd_start[k] + L) begin
      e_addr = {2'b00, rd_addr[k]};
      e_rden = (t < rd_start[k] + L);
    end else if (g) begin
      e_addr = {2'b00, dadr[k][w]};
      e_rden = !dwe[k][w];
      e_wren = dwe[k][w];
      cd     = dwe[k][w];
      e_data = dwd[k][w];
    end else begin
      cd = 1'b1;
    end
    if (rd_on[k] && t >= rd_start[k] + L) rd_on[k] = 1'b0;

    chk($sformatf("L%0d t%0d gnt0", L, t),    32'(gnt0[k]),    32'(g && !w));
    chk($sformatf("L%0d t%0d gnt1", L, t),    32'(gnt1[k]),    32'(g && w));
    chk($sformatf("L%0d t%0d rvalid0", L, t), 32'(rvalid0[k]), 32'(ev0));
    chk($sformatf("L%0d t%0d rvalid1", L, t), 32'(rvalid1[k]), 32'(ev1));
    chk($sformatf("L%0d t%0d rdata", L, t),   32'(rdata[k]),   32'(exp_rdata[k]));
    chk($sformatf("L%0d t%0d ram_rden", L, t), 32'(ram_rden[k]), 32'(e_rden));
    chk($sformatf("L%0d t%0d ram_wren", L, t), 32'(ram_wren[k]), 32'(e_wren));
    chk($sformatf("L%0d t%0d ram_address", L, t), 32'(ram_address[k]), 32'(e_addr));
    if (cd) chk($sformatf("L%0d t%0d ram_data", L, t), 32'(ram_data[k]), 32'(e_data));

    if (g) begin
      act[k][w] = 1'b0;
      lg_m[k]   = w;
      if (dwe[k][w]) begin
        ref_mem[k][dadr[k][w]] = {1'b1, dwd[k][w]};
        free_at[k] = t + 1;
      end else begin
        free_at[k]  = t + L + 1;
        rd_on[k]    = 1'b1;
        rd_start[k] = t;
        rd_addr[k]  = dadr[k][w];
        pend_on[k]  = 1'b1;
        pend_due[k] = t + L + 1;
        pend_own[k] = w;
        pend_dat[k] = ref_rd(k, dadr[k][w]);
        // Occasionally abort this read with a reset in the following cycle,
        // then have both masters contend right after the reset.
        if (t >= 60 && n_rst[k] < 3 && $urandom_range(0, 3) == 0) begin
          rst_next[k] = 1'b1;
          n_rst[k]++;
          force_at[k] = t + 2;
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      req0[k] = 1'b0; req1[k] = 1'b0; we0[k] = 1'b0; we1[k] = 1'b0;
      addr0[k] = 16'h0; addr1[k] = 16'h0; wdata0[k] = 8'h0; wdata1[k] = 8'h0;
      act[k][0] = 1'b0; act[k][1] = 1'b0;
      rst_next[k] = 1'b0; n_rst[k] = 0; force_at[k] = -1;
      model_reset(k, 0);
    end

    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        rst[k]      = (cyc < 3) || rst_next[k];
        rst_next[k] = 1'b0;
        drive(k, cyc);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst[k]) model_reset(k, cyc);
        else        model_step(k, cyc);
      end
    end

    for (int k = 0; k < 2; k++)
      chk($sformatf("L%0d mid_read_reset_seen", lat(k)), 32'(n_rst[k] > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter for the single-port 16 KB RAM shared by the CPU control unit and a second bus master (program loader / debug port). It serializes requests, sequences the RAM's fixed read latency, and returns read data with a one-cycle valid strobe. This lets the control unit stop driving the RAM directly: the arbiter sits between both masters and the `ram` instance.

## Interface
- `ADDR_W`, 16, address width.
- `DATA_W`, 8, data width.
- `READ_LAT`, 2, cycles from the first cycle a read address is presented until `ram_q` is valid; legal range 1..7.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req0` / `req1`  in  1  request from master 0 (CPU) / master 1 (loader).
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  ADDR_W  request address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `gnt0` / `gnt1`  out  1  request accepted this cycle (combinational, IDLE only).
- `rvalid0` / `rvalid1`  out  1  one-cycle strobe; `rdata` holds the read result.
- `rdata`  out  DATA_W  registered read data, shared by both masters.
- `ram_address`  out  ADDR_W  to RAM.
- `ram_data`  out  DATA_W  to RAM.
- `ram_rden`, `ram_wren`  out  1  to RAM.
- `ram_q`  in  DATA_W  from RAM.

## Operation
- FSM states:
  - IDLE.
  - RD_WAIT: down-counter `cnt`, 3 bits.
  - RD_DONE.
- IDLE:
  - No request: all RAM outputs are 0, no grant.
  - Select a master by round-robin. The last-granted pointer `lg` (0/1) favours the other master on a tie; a sole requester always wins.
  - On grant, assert `gntN`, drive `ram_address = addrN`, and set `lg <= N`.
- Granted write:
  - `ram_wren = 1` and `ram_data = wdataN` in the grant cycle.
  - Stay in IDLE. The next grant can occur on the next cycle.
- Granted read:
  - `ram_rden = 1` in the grant cycle.
  - Latch `addrN` into `raddr` and the owner N into `own`.
  - Load `cnt = READ_LAT-1`, then go to RD_WAIT. If READ_LAT = 1, go straight to RD_DONE.
- RD_WAIT:
  - Drive `ram_address = raddr` and `ram_rden = 1`.
  - Decrement `cnt`; move to RD_DONE when `cnt` reaches 1.
- RD_DONE:
  - Drive `ram_address = raddr`; `ram_rden = 0`.
  - Capture `rdata <= ram_q`, pulse `rvalid<own>` on the next cycle, and return to IDLE.
- No grants are issued outside IDLE. Requesters hold `req`, `we`, `addr` and `wdata` stable until they see `gnt`.
- `gnt` is never asserted for a deasserted `req`. At most one of `gnt0` and `gnt1` is high in any cycle.
- `rdata` holds its value until the next read completes.

## Timing
- Read granted in cycle T:
  - `ram_rden` is high T .. T+READ_LAT-1.
  - `ram_q` is sampled at the end of T+READ_LAT.
  - `rvalid` is high in T+READ_LAT+1.
  - The earliest next grant is T+READ_LAT+1, concurrent with `rvalid`.
  - Read throughput is one per READ_LAT+1 cycles.
- Write granted in T: RAM written at the edge ending T; a new grant is possible in T+1.
- Sustained contention alternates strictly 0,1,0,1,…
- Reset values:
  - State IDLE, `cnt` 0, `lg` 1 (master 0 wins the first tie), `own` 0.
  - `raddr` 0, `rdata` 0, `rvalid0` and `rvalid1` 0.
  - All RAM controls 0.
- Reset mid-read: the pending read is discarded and no `rvalid` is issued. Requesters must re-request after reset.
- A request arriving while busy stalls (no `gnt`) until IDLE. It is served then, subject to round-robin.

## Test plan
- Single read, master 0, RAM[0x1000]=0xA9, READ_LAT=2: `req0`, `we0=0`, `addr0=0x1000` at T -> `gnt0` at T; `rden` T..T+1; `rvalid0` at T+3 with `rdata=0xA9`; `rvalid1` stays 0.
- Write then read, master 1: write 0x5C to 0x0042 at T -> `gnt1`@T, `wren`@T; read 0x0042 at T+1 -> `rvalid1`@T+4, `rdata=0x5C`.
- Contention: `req0` and `req1` held with continuous reads from reset -> grant order 0,1,0,1; each grant 3 cycles apart; each `rvalid` routed to the correct owner.
- Busy stall: `req1` read granted at T; `req0` write raised at T+1 -> `gnt0` not before T+3; write lands at T+3; `gnt0` and `gnt1` never high together.
- Reset mid-read: grant a read at T, assert `reset` at T+1 -> no `rvalid` ever; `rdata=0`; the first tie after reset goes to master 0.
- READ_LAT=4 instance: read granted at T -> `rden` high T..T+3; `rvalid` at T+5; data equals preloaded RAM contents.
